mdio_master: RTL and testbench

MDIO_MASTER -- requirements
Module: mdio_master

---
 rtl/mdio_master.sv | 134 +++++++++++++
 tb/tb_mdio_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// MDIO clause 22/45 management-frame master.
// One command in flight; MDC half-period is DIV clk cycles.
module mdio_master #(
  parameter int DIV      = 2,
  parameter int PRE_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_st,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);
  localparam int N = PRE_BITS + 32;
  localparam logic [8:0] HALF  = 9'(DIV);
  localparam logic [8:0] LAST  = 9'(2 * DIV - 1);
  localparam logic [5:0] BLAST = 6'(N - 1);
  localparam logic [5:0] TA1   = 6'(PRE_BITS + 14);
  localparam logic [5:0] TA2   = 6'(PRE_BITS + 15);
  localparam logic [5:0] D0    = 6'(PRE_BITS + 16);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  state_t      state, state_n;
  logic [8:0]  div_cnt, div_n;
  logic [5:0]  bit_cnt, bit_n;
  logic [31:0] frame, frame_n;
  logic        rd, rd_n;
  logic [15:0] rdata;
  logic        ta_bad;
  logic        accept, illegal, bit_end, sample;
  logic        mdc_n, oe_n, o_n;
  logic [63:0] word;
  logic [5:0]  idx;

  assign cmd_ready = (state == IDLE) && rst_n;
  assign accept    = cmd_valid && cmd_ready;
  // st=1x, or st=01 with op 00/11
  assign illegal   = cmd_st[1] ||
                     (cmd_st[0] && (cmd_op[1] == cmd_op[0]));
  assign bit_end   = (state == SHIFT) && (div_cnt == LAST);
  assign sample    = (state == SHIFT) && (div_cnt == HALF - 9'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = illegal ? RESP : SHIFT;
          div_n   = '0;
          bit_n   = '0;
        end
      end
      SHIFT: begin
        div_n = div_cnt + 9'd1;
        if (bit_end) begin
          div_n = '0;
          bit_n = bit_cnt + 6'd1;
          if (bit_cnt == BLAST) state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    frame_n = frame;
    rd_n    = rd;
    if (accept) begin
      frame_n = {cmd_st, cmd_op, cmd_phy, cmd_reg, 2'b10, cmd_data};
      rd_n    = cmd_op[1];
    end
    word  = {32'hFFFF_FFFF, frame_n};
    idx   = BLAST - bit_n;
    mdc_n = (state_n == SHIFT) && (div_n >= HALF);
    oe_n  = (state_n == SHIFT) && (!rd_n || (bit_n < TA1));
    o_n   = oe_n ? word[idx] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      frame     <= '0;
      rd        <= 1'b0;
      mdc       <= 1'b0;
      mdio_oe   <= 1'b0;
      mdio_o    <= 1'b1;
      rdata     <= '0;
      ta_bad    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      div_cnt   <= div_n;
      bit_cnt   <= bit_n;
      frame     <= frame_n;
      rd        <= rd_n;
      mdc       <= mdc_n;
      mdio_oe   <= oe_n;
      mdio_o    <= o_n;
      if (sample && (bit_cnt == TA2)) ta_bad <= mdio_i;
      if (sample && (bit_cnt >= D0))  rdata  <= {rdata[14:0], mdio_i};
      rsp_valid <= (state_n == RESP);
      if (state_n == RESP) begin
        if (state == IDLE) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end else begin
          rsp_data <= rd ? rdata : 16'h0;
          rsp_err  <= rd && ta_bad;
        end
      end
    end
  end
endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master: default build plus a
// DIV=1 / PRE_BITS=0 build, with a simple PHY read model.
module tb_mdio_master;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  c_st = '0, c_op = '0;
  logic [4:0]  c_phy = '0, c_reg = '0;
  logic [15:0] c_data = '0;
  logic        mdio_i = 1'b1;

  logic        a_ready, a_rv, a_re, a_mdc, a_o, a_oe;
  logic [15:0] a_rd;
  logic        b_ready, b_rv, b_re, b_mdc, b_o, b_oe;
  logic [15:0] b_rd;
  logic        a_valid, b_valid;

  assign a_valid = cmd_valid && !sel;
  assign b_valid = cmd_valid && sel;

  mdio_master u_a (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_st(c_st), .cmd_op(c_op), .cmd_phy(c_phy),
    .cmd_reg(c_reg), .cmd_data(c_data),
    .rsp_valid(a_rv), .rsp_data(a_rd), .rsp_err(a_re),
    .mdc(a_mdc), .mdio_o(a_o), .mdio_oe(a_oe), .mdio_i(mdio_i)
  );

  mdio_master #(.DIV(1), .PRE_BITS(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_st(c_st), .cmd_op(c_op), .cmd_phy(c_phy),
    .cmd_reg(c_reg), .cmd_data(c_data),
    .rsp_valid(b_rv), .rsp_data(b_rd), .rsp_err(b_re),
    .mdc(b_mdc), .mdio_o(b_o), .mdio_oe(b_oe), .mdio_i(mdio_i)
  );

  logic        m_ready, m_rv, m_re, m_mdc, m_o, m_oe;
  logic [15:0] m_rd;
  assign m_ready = sel ? b_ready : a_ready;
  assign m_rv    = sel ? b_rv    : a_rv;
  assign m_re    = sel ? b_re    : a_re;
  assign m_rd    = sel ? b_rd    : a_rd;
  assign m_mdc   = sel ? b_mdc   : a_mdc;
  assign m_o     = sel ? b_o     : a_o;
  assign m_oe    = sel ? b_oe    : a_oe;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PHY model: tracks the bit index from MDC falls, drives TA2/data
  logic        phy_en = 1'b0;
  logic [15:0] phy_data = '0;
  int          bitc = 0;
  logic        pm = 1'b0, poe = 1'b0;
  always @(negedge clk) begin
    int pre;
    pre = sel ? 0 : 32;
    if (m_oe && !poe) bitc = 0;
    else if (pm && !m_mdc) bitc = bitc + 1;
    pm  = m_mdc;
    poe = m_oe;
    if (!phy_en) mdio_i = 1'b1;
    else if (bitc == pre + 15) mdio_i = 1'b0;
    else if (bitc >= pre + 16 && bitc <= pre + 31)
      mdio_i = phy_data[4'(pre + 31 - bitc)];
    else mdio_i = 1'b1;
  end

  typedef struct {
    logic [15:0] d;
    logic        e;
    int          when;
  } exp_t;
  exp_t q[$];

  int errs = 0;
  int checks = 0;
  int t_acc = 0;
  int last_rsp = 0;

  task automatic send(input logic [1:0] s, input logic [1:0] o,
                      input logic [4:0] p, input logic [4:0] r,
                      input logic [15:0] d, input logic [15:0] ed,
                      input logic ee, input int lat);
    int   n;
    exp_t x;
    n = 0;
    @(negedge clk);
    while (!m_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (m_ready !== 1'b1) begin
      errs++;
      $display("FAIL cmd_ready_wait: got %b want 1", m_ready);
    end
    c_st = s; c_op = o; c_phy = p; c_reg = r; c_data = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    t_acc = cyc;
    cmd_valid = 1'b0;
    c_st = 2'($urandom); c_op = 2'($urandom);
    c_phy = 5'($urandom); c_reg = 5'($urandom);
    c_data = 16'($urandom);
    x.d = ed; x.e = ee; x.when = t_acc + lat;
    q.push_back(x);
  endtask

  task automatic collect(output logic [63:0] bits,
                         output logic [63:0] oes, output int nb);
    int   n;
    logic p, done;
    exp_t x;
    n = 0; p = 1'b0; done = 1'b0;
    bits = '0; oes = '0; nb = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      if (m_mdc && !p) begin
        bits = {bits[62:0], m_o};
        oes  = {oes[62:0], m_oe};
        nb++;
      end
      p = m_mdc;
      if (m_rv) begin
        done = 1'b1;
        last_rsp = cyc;
        checks++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL rsp_unexpected: rsp_valid with empty queue");
        end else begin
          x = q.pop_front();
          checks += 2;
          if (m_rd !== x.d || m_re !== x.e) begin
            errs++;
            $display("FAIL rsp_value: got %h/%b want %h/%b",
                     m_rd, m_re, x.d, x.e);
          end
          if (cyc != x.when) begin
            errs++;
            $display("FAIL rsp_latency: got %0d want %0d", cyc, x.when);
          end
        end
      end
    end
    if (!done) begin
      checks++;
      errs++;
      $display("FAIL rsp_timeout: no rsp_valid within 2000 cycles");
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (a_mdc !== 1'b0) begin errs++; $display("FAIL rst_mdc: got %b want 0", a_mdc); end
    if (a_oe !== 1'b0) begin errs++; $display("FAIL rst_oe: got %b want 0", a_oe); end
    if (a_o !== 1'b1) begin errs++; $display("FAIL rst_mdio_o: got %b want 1", a_o); end
    if (a_ready !== 1'b0) begin errs++; $display("FAIL rst_ready: got %b want 0", a_ready); end
    if (a_rv !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid: got %b want 0", a_rv); end
    if (a_re !== 1'b0) begin errs++; $display("FAIL rst_rsp_err: got %b want 0", a_re); end
    if (a_rd !== 16'h0) begin errs++; $display("FAIL rst_rsp_data: got %h want 0", a_rd); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin errs++; $display("FAIL rel_ready: got %b want 1", a_ready); end
  endtask

  task automatic test_c22_write;
    logic [63:0] bits, oes, eb;
    int nb;
    sel = 1'b0; phy_en = 1'b0;
    eb = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1140};
    send(2'b01, 2'b01, 5'h01, 5'h00, 16'h1140, 16'h0, 1'b0, 256);
    collect(bits, oes, nb);
    checks += 3;
    if (nb != 64) begin errs++; $display("FAIL wr_nbits: got %0d want 64", nb); end
    if (bits !== eb) begin errs++; $display("FAIL wr_bits: got %h want %h", bits, eb); end
    if (oes !== '1) begin errs++; $display("FAIL wr_oe: got %h want all ones", oes); end
    @(negedge clk);
    checks++;
    if (m_rv !== 1'b0) begin errs++; $display("FAIL rsp_pulse: got %b want 0", m_rv); end
  endtask

  task automatic test_c22_read;
    logic [63:0] bits, oes, eb;
    int nb;
    sel = 1'b0; phy_en = 1'b1; phy_data = 16'h796D;
    eb = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h01, 5'h01, 18'h3FFFF};
    send(2'b01, 2'b10, 5'h01, 5'h01, 16'h0, 16'h796D, 1'b0, 256);
    collect(bits, oes, nb);
    checks += 2;
    if (oes !== 64'hFFFF_FFFF_FFFC_0000) begin
      errs++; $display("FAIL rd_oe: got %h want fffffffffffc0000", oes);
    end
    if (bits !== eb) begin errs++; $display("FAIL rd_bits: got %h want %h", bits, eb); end
    repeat (5) @(negedge clk);
    checks++;
    if (m_rd !== 16'h796D) begin errs++; $display("FAIL rsp_hold: got %h want 796d", m_rd); end
  endtask

  task automatic test_read_no_phy;
    logic [63:0] bits, oes;
    int nb;
    sel = 1'b0; phy_en = 1'b0;
    send(2'b01, 2'b10, 5'h01, 5'h01, 16'h0, 16'hFFFF, 1'b1, 256);
    collect(bits, oes, nb);
  endtask

  task automatic test_back_to_back;
    logic [63:0] bits, oes;
    logic [31:0] eb;
    int nb;
    sel = 1'b1; phy_en = 1'b1; phy_data = 16'hBEEF;
    eb = {2'b00, 2'b00, 5'h03, 5'h01, 2'b10, 16'h0010};
    send(2'b00, 2'b00, 5'h03, 5'h01, 16'h0010, 16'h0, 1'b0, 64);
    collect(bits, oes, nb);
    checks += 3;
    if (nb != 32) begin errs++; $display("FAIL c45_nbits: got %0d want 32", nb); end
    if (bits[31:0] !== eb) begin errs++; $display("FAIL c45_bits: got %h want %h", bits[31:0], eb); end
    if (oes[31:0] !== 32'hFFFF_FFFF) begin errs++; $display("FAIL c45_oe: got %h want ffffffff", oes[31:0]); end
    send(2'b00, 2'b11, 5'h03, 5'h01, 16'h0, 16'hBEEF, 1'b0, 64);
    checks++;
    if (t_acc != last_rsp + 2) begin
      errs++; $display("FAIL b2b_accept: got %0d want %0d", t_acc, last_rsp + 2);
    end
    collect(bits, oes, nb);
    checks++;
    if (oes[31:0] !== 32'hFFFC_0000) begin errs++; $display("FAIL c45_rd_oe: got %h want fffc0000", oes[31:0]); end
    phy_data = 16'h1234;
    send(2'b00, 2'b10, 5'h07, 5'h03, 16'h0, 16'h1234, 1'b0, 64);
    collect(bits, oes, nb);
  endtask

  task automatic test_illegal;
    logic [63:0] bits, oes;
    int nb;
    sel = 1'b0; phy_en = 1'b0;
    send(2'b01, 2'b11, 5'h01, 5'h02, 16'h5555, 16'h0, 1'b1, 0);
    collect(bits, oes, nb);
    checks++;
    if (nb != 0) begin errs++; $display("FAIL ill_mdc: got %0d toggles want 0", nb); end
    send(2'b10, 2'b01, 5'h01, 5'h02, 16'h5555, 16'h0, 1'b1, 0);
    collect(bits, oes, nb);
    send(2'b01, 2'b00, 5'h01, 5'h02, 16'h5555, 16'h0, 1'b1, 0);
    collect(bits, oes, nb);
    checks++;
    if (nb != 0) begin errs++; $display("FAIL ill_mdc2: got %0d toggles want 0", nb); end
  endtask

  task automatic test_reset_abort;
    int n, nb, rv, tg;
    logic p;
    n = 0; nb = 0; rv = 0; tg = 0; p = 1'b0;
    sel = 1'b0; phy_en = 1'b0;
    send(2'b01, 2'b01, 5'h02, 5'h04, 16'hA5A5, 16'h0, 1'b0, 256);
    while (nb < 21 && n < 2000) begin
      @(negedge clk);
      n++;
      if (m_mdc && !p) nb++;
      p = m_mdc;
    end
    checks++;
    if (nb != 21) begin errs++; $display("FAIL abort_reach: got %0d want 21", nb); end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (m_mdc !== 1'b0) begin errs++; $display("FAIL abort_mdc: got %b want 0", m_mdc); end
    if (m_oe !== 1'b0) begin errs++; $display("FAIL abort_oe: got %b want 0", m_oe); end
    if (m_o !== 1'b1) begin errs++; $display("FAIL abort_o: got %b want 1", m_o); end
    if (m_ready !== 1'b0) begin errs++; $display("FAIL abort_ready: got %b want 0", m_ready); end
    repeat (3) @(negedge clk);
    checks++;
    if (m_mdc !== 1'b0 || m_oe !== 1'b0) begin
      errs++; $display("FAIL abort_hold: got %b/%b want 0/0", m_mdc, m_oe);
    end
    q.delete();
    rst_n = 1'b1;
    #1;
    checks++;
    if (m_ready !== 1'b1) begin errs++; $display("FAIL abort_ready_rel: got %b want 1", m_ready); end
    repeat (300) begin
      @(negedge clk);
      if (m_rv) rv++;
      if (m_mdc) tg++;
    end
    checks += 2;
    if (rv != 0) begin errs++; $display("FAIL abort_rsp: got %0d want 0", rv); end
    if (tg != 0) begin errs++; $display("FAIL abort_idle: got %0d mdc-high want 0", tg); end
  endtask

  initial begin
    test_reset();
    test_c22_write();
    test_c22_read();
    test_read_no_phy();
    test_back_to_back();
    test_illegal();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
